hdmi_tx_cfg_sequencer: RTL and testbench

//  Brings up the HDMI transmitter after reset: walks a register table and issues one I2C byte-write per entry.

---
 rtl/hdmi_tx_cfg_pkg.sv | 29 ++
 rtl/hdmi_tx_intn_debounce.sv | 64 ++++++
 rtl/hdmi_tx_cfg_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_hdmi_tx_cfg_sequencer.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_tx_cfg_pkg.sv
// Shared definitions for the HDMI transmitter configuration sequencer.
//  - cfg_state_e : sequencer FSM state encoding
//  - CFG_END     : table register code marking the end of the table
//  - CFG_DELAY   : table register code for a delay entry (value = units of DELAY_UNIT cycles)
//  - max_u       : constant-expression helper for sizing counters
package hdmi_tx_cfg_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StPwrWait,
        StFetch,
        StLatch,
        StReq,
        StWaitAck,
        StDelay,
        StNext,
        StDone,
        StError
    } cfg_state_e;

    localparam logic [7:0]  CFG_END    = 8'hFF;
    localparam logic [7:0]  CFG_DELAY  = 8'hFE;
    localparam int unsigned DELAY_UNIT = 1024;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hdmi_tx_intn_debounce.sv
// Synchronises and debounces the transmitter's active-low interrupt line.
// The 2-FF synchronised value must differ from the accepted value for DEBOUNCE consecutive
// cycles before it is accepted; an accepted 1->0 transition produces a one-cycle pulse.
//  clk     in  system clock
//  resetn  in  synchronous reset, active low
//  intn_i  in  raw asynchronous interrupt, active low
//  fall_o  out one-cycle pulse on an accepted falling edge
module hdmi_tx_intn_debounce
    import hdmi_tx_cfg_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 1024
) (
    input  logic clk,
    input  logic resetn,
    input  logic intn_i,
    output logic fall_o
);

    localparam int unsigned CW = max_u($clog2(DEBOUNCE), 1);
    localparam logic [CW-1:0] CntMax = (DEBOUNCE == 0) ? '0 : CW'(DEBOUNCE - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fall_q, fall_d;

    always_comb begin
        sync1_d  = intn_i;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        fall_d   = 1'b0;
        // Any cycle where the synchronised input agrees with the accepted value restarts the count.
        if (sync2_q != stable_q) begin
            if (cnt_q == CntMax) begin
                stable_d = sync2_q;
                fall_d   = stable_q & ~sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Idle level of the interrupt is high, so the chain resets to 1.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            fall_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            fall_q   <= fall_d;
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/hdmi_tx_cfg_sequencer.sv
// HDMI transmitter bring-up sequencer. Walks a register table held in an external synchronous
// ROM and issues one I2C byte-write per entry, with NAK retries, delay entries and an end
// marker. A debounced falling edge of hdmi_intn (hot-plug) re-runs the whole table.
//  clk, resetn         clock, synchronous active-low reset
//  start               pulse: run the table (ignored while busy)
//  hdmi_intn           asynchronous active-low interrupt from the transmitter
//  cfg_addr/cfg_data   table ROM read port, data valid one cycle after the address
//  i2c_req/dev/reg/data/ack/nak   byte-write handshake with the I2C master
//  busy, done, error, err_index   status towards the PS GPIO
module hdmi_tx_cfg_sequencer
    import hdmi_tx_cfg_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 16,
    parameter logic [6:0]  DEV_ADDR  = 7'h39,
    parameter int unsigned PWR_WAIT  = 200000,
    parameter int unsigned RETRY_MAX = 3,
    parameter int unsigned DEBOUNCE  = 1024,
    localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          hdmi_intn,
    output logic [AW-1:0] cfg_addr,
    input  logic [15:0]   cfg_data,
    output logic          i2c_req,
    output logic [6:0]    i2c_dev,
    output logic [7:0]    i2c_reg,
    output logic [7:0]    i2c_data,
    input  logic          i2c_ack,
    input  logic          i2c_nak,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic [AW-1:0] err_index
);

    // One down-counter serves both the power-up wait and delay entries (max 255 * DELAY_UNIT).
    localparam int unsigned WaitW = max_u($clog2(PWR_WAIT + 1), $clog2(256 * DELAY_UNIT));
    localparam int unsigned RW    = max_u($clog2(RETRY_MAX + 1), 1);
    localparam logic [WaitW-1:0] PwrLoad  = (PWR_WAIT == 0) ? '0 : WaitW'(PWR_WAIT - 1);
    localparam logic [AW-1:0]    LastIdx  = AW'(NUM_REGS - 1);
    localparam logic [RW-1:0]    RetryMax = RW'(RETRY_MAX);

    cfg_state_e       state_q, state_d;
    logic [AW-1:0]    index_q, index_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             req_q, req_d;
    logic [7:0]       reg_q, reg_d;
    logic [7:0]       data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [AW-1:0]    err_index_q, err_index_d;
    logic             pending_q, pending_d;
    logic             intn_fall;

    hdmi_tx_intn_debounce #(
        .DEBOUNCE(DEBOUNCE)
    ) u_intn_debounce (
        .clk   (clk),
        .resetn(resetn),
        .intn_i(hdmi_intn),
        .fall_o(intn_fall)
    );

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        retry_d     = retry_q;
        wait_d      = wait_q;
        req_d       = req_q;
        reg_d       = reg_q;
        data_d      = data_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        err_index_d = err_index_q;
        // Any number of hot-plug edges while busy collapse into this single flag.
        pending_d   = pending_q | intn_fall;

        unique case (state_q)
            StIdle: begin
                if (start || pending_q) begin
                    state_d   = StPwrWait;
                    pending_d = 1'b0;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    index_d   = '0;
                    retry_d   = '0;
                    busy_d    = 1'b1;
                    wait_d    = PwrLoad;
                end
            end
            StPwrWait: begin
                if (wait_q == '0) begin
                    state_d = StFetch;
                end else begin
                    wait_d = wait_q - WaitW'(1);
                end
            end
            StFetch: begin
                state_d = StLatch;
            end
            StLatch: begin
                // cfg_data now reflects the address presented during FETCH.
                if (cfg_data[15:8] == CFG_END) begin
                    state_d = StDone;
                end else if (cfg_data[15:8] == CFG_DELAY) begin
                    if (cfg_data[7:0] == 8'd0) begin
                        state_d = StNext;
                    end else begin
                        wait_d  = WaitW'(cfg_data[7:0]) * WaitW'(DELAY_UNIT) - WaitW'(1);
                        state_d = StDelay;
                    end
                end else begin
                    reg_d   = cfg_data[15:8];
                    data_d  = cfg_data[7:0];
                    state_d = StReq;
                end
            end
            StReq: begin
                req_d   = 1'b1;
                state_d = StWaitAck;
            end
            StWaitAck: begin
                if (i2c_ack) begin
                    // Re-entry through StReq guarantees a low cycle between requests.
                    req_d = 1'b0;
                    if (!i2c_nak) begin
                        retry_d = '0;
                        state_d = StNext;
                    end else if (retry_q < RetryMax) begin
                        retry_d = retry_q + RW'(1);
                        state_d = StReq;
                    end else begin
                        retry_d     = '0;
                        err_index_d = index_q;
                        state_d     = StError;
                    end
                end
            end
            StDelay: begin
                if (wait_q == '0) begin
                    state_d = StNext;
                end else begin
                    wait_d = wait_q - WaitW'(1);
                end
            end
            StNext: begin
                if (index_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    index_d = index_q + AW'(1);
                    state_d = StFetch;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            StError: begin
                error_d = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= StIdle;
            index_q     <= '0;
            retry_q     <= '0;
            wait_q      <= '0;
            req_q       <= 1'b0;
            reg_q       <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= '0;
            pending_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            retry_q     <= retry_d;
            wait_q      <= wait_d;
            req_q       <= req_d;
            reg_q       <= reg_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_index_q <= err_index_d;
            pending_q   <= pending_d;
        end
    end

    assign cfg_addr  = index_q;
    assign i2c_req   = req_q;
    assign i2c_dev   = DEV_ADDR;
    assign i2c_reg   = reg_q;
    assign i2c_data  = data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_index = err_index_q;

endmodule

// File: tb/tb_hdmi_tx_cfg_sequencer.sv
// Scoreboard bench for hdmi_tx_cfg_sequencer: a table-walking reference model pushes the
// expected write sequence and final status of every run; a monitor pops and compares them
// whenever the DUT raises a request or finishes a run.
module tb_hdmi_tx_cfg_sequencer;

    localparam int unsigned NUM_REGS  = 8;
    localparam int unsigned AW        = 3;
    localparam int unsigned PWR_WAIT  = 16;
    localparam int unsigned RETRY_MAX = 3;
    localparam int unsigned DEBOUNCE  = 1024;
    localparam logic [6:0]  DEV_ADDR  = 7'h39;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          hdmi_intn = 1'b1;
    logic [AW-1:0] cfg_addr;
    logic [15:0]   cfg_data = '0;
    logic          i2c_req;
    logic [6:0]    i2c_dev;
    logic [7:0]    i2c_reg;
    logic [7:0]    i2c_data;
    logic          i2c_ack = 1'b0;
    logic          i2c_nak = 1'b0;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] err_index;

    hdmi_tx_cfg_sequencer #(
        .NUM_REGS (NUM_REGS),
        .DEV_ADDR (DEV_ADDR),
        .PWR_WAIT (PWR_WAIT),
        .RETRY_MAX(RETRY_MAX),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start    (start),
        .hdmi_intn(hdmi_intn),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .i2c_req  (i2c_req),
        .i2c_dev  (i2c_dev),
        .i2c_reg  (i2c_reg),
        .i2c_data (i2c_data),
        .i2c_ack  (i2c_ack),
        .i2c_nak  (i2c_nak),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .err_index(err_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r;
        logic [7:0] d;
        int         min_gap;   // -1: first write of a run, gap not checked
    } exp_req_t;

    typedef struct {
        logic          done;
        logic          error;
        logic [AW-1:0] idx;
    } exp_stat_t;

    exp_req_t  exp_reqs[$];
    exp_stat_t exp_stats[$];

    logic [15:0] rom [NUM_REGS];
    int          nak_plan [256];
    int          nak_left [256];
    bit          slave_hold = 1'b0;

    int     checks = 0;
    int     errors = 0;
    int     exp_runs = 0;
    int     busy_rises = 0;
    longint cyc = 0;

    // Synchronous config ROM: data one cycle after the address.
    always @(posedge clk) cfg_data <= rom[cfg_addr];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    task automatic fail(input string what);
        checks++;
        errors++;
        $display("FAIL %s", what);
    endtask

    // Reference model: walk the table as written, one write per attempt, NAK budget per register.
    function automatic void model_run();
        int        pend = 0;
        bit        seen = 1'b0;
        exp_req_t  e;
        exp_stat_t s;
        exp_runs++;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            logic [7:0] r;
            logic [7:0] v;
            r = rom[i][15:8];
            v = rom[i][7:0];
            if (r == 8'hFF) begin
                s.done = 1'b1; s.error = 1'b0; s.idx = AW'(i);
                exp_stats.push_back(s);
                return;
            end
            if (r == 8'hFE) begin
                pend += int'(v) * 1024;
                continue;
            end
            for (int a = 0; a <= int'(RETRY_MAX); a++) begin
                e.r = r;
                e.d = v;
                if (a > 0) e.min_gap = 2;
                else if (seen) e.min_gap = (pend > 2) ? pend : 2;
                else e.min_gap = -1;
                exp_reqs.push_back(e);
                seen = 1'b1;
                pend = 0;
                if (a >= nak_plan[r]) break;
                if (a == int'(RETRY_MAX)) begin
                    s.done = 1'b0; s.error = 1'b1; s.idx = AW'(i);
                    exp_stats.push_back(s);
                    return;
                end
            end
        end
        s.done = 1'b1; s.error = 1'b0; s.idx = AW'(NUM_REGS - 1);
        exp_stats.push_back(s);
    endfunction

    // I2C master stand-in: acks each request after 0..3 cycles, NAKing from the per-register budget.
    initial begin : slave
        int lat;
        lat = -1;
        forever begin
            @(posedge clk);
            #1;
            i2c_ack = 1'b0;
            i2c_nak = 1'b0;
            if (!resetn || !i2c_req || slave_hold) begin
                lat = -1;
            end else begin
                if (lat < 0) lat = $urandom_range(0, 3);
                if (lat == 0) begin
                    i2c_ack = 1'b1;
                    if (nak_left[i2c_reg] > 0) begin
                        i2c_nak = 1'b1;
                        nak_left[i2c_reg]--;
                    end
                    lat = -1;
                end else begin
                    lat--;
                end
            end
        end
    end

    logic      prev_req = 1'b0;
    logic      prev_busy = 1'b0;
    longint    ack_cyc = 0;
    exp_req_t  mon_e;
    exp_stat_t mon_s;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prev_req  = 1'b0;
                prev_busy = 1'b0;
                continue;
            end
            if (i2c_req && !prev_req) begin
                if (exp_reqs.size() == 0) begin
                    fail($sformatf("unexpected_req: got reg 0x%0h data 0x%0h, required none",
                                   i2c_reg, i2c_data));
                end else begin
                    mon_e = exp_reqs.pop_front();
                    check("req_reg", 32'(i2c_reg), 32'(mon_e.r));
                    check("req_data", 32'(i2c_data), 32'(mon_e.d));
                    check("req_dev", 32'(i2c_dev), 32'(DEV_ADDR));
                    if (mon_e.min_gap >= 0) begin
                        checks++;
                        if ((cyc - ack_cyc) < longint'(mon_e.min_gap)) begin
                            errors++;
                            $display("FAIL req_gap: got %0d cycles, required >= %0d",
                                     cyc - ack_cyc, mon_e.min_gap);
                        end
                    end
                end
            end
            if (i2c_req && i2c_ack) ack_cyc = cyc;
            if (busy && !prev_busy) begin
                busy_rises++;
                check("run_entry_done", 32'(done), 32'(0));
                check("run_entry_error", 32'(error), 32'(0));
                check("run_entry_addr", 32'(cfg_addr), 32'(0));
            end
            if (!busy && prev_busy) begin
                if (exp_stats.size() == 0) begin
                    fail($sformatf("unexpected_run_end: got done=%0d error=%0d, required none",
                                   done, error));
                end else begin
                    mon_s = exp_stats.pop_front();
                    check("end_done", 32'(done), 32'(mon_s.done));
                    check("end_error", 32'(error), 32'(mon_s.error));
                    check("end_index", 32'(cfg_addr), 32'(mon_s.idx));
                    if (mon_s.error) check("err_index", 32'(err_index), 32'(mon_s.idx));
                end
            end
            prev_req  = i2c_req;
            prev_busy = busy;
        end
    end

    task automatic wait_busy(input logic level, input int budget, input string name);
        int n = 0;
        while (busy !== level && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy !== level) fail($sformatf("%s: busy=%0b after %0d cycles, required %0b",
                                           name, busy, budget, level));
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic clear_table();
        for (int i = 0; i < int'(NUM_REGS); i++) rom[i] = 16'hFF00;
        for (int i = 0; i < 256; i++) nak_plan[i] = 0;
    endtask

    task automatic run_table(input string name);
        model_run();
        nak_left = nak_plan;
        pulse_start();
        wait_busy(1'b1, 50, {name, "_start"});
        wait_busy(1'b0, 30000, {name, "_end"});
        repeat (3) @(negedge clk);
    endtask

    task automatic intn_low(input int cycles);
        @(negedge clk);
        hdmi_intn = 1'b0;
        repeat (cycles) @(negedge clk);
        hdmi_intn = 1'b1;
    endtask

    task automatic load_basic();
        clear_table();
        rom[0] = 16'h4110;
        rom[1] = 16'h9803;
        rom[2] = 16'hFF00;
    endtask

    initial begin : watchdog
        #1500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        logic [7:0] r;
        clear_table();
        nak_left = nak_plan;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_error", 32'(error), 32'(0));
        check("rst_req", 32'(i2c_req), 32'(0));
        check("rst_addr", 32'(cfg_addr), 32'(0));
        check("rst_err_index", 32'(err_index), 32'(0));
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // Basic two-write table
        load_basic();
        run_table("basic");

        // Entry 1 NAKs beyond the retry budget, then within it
        load_basic();
        nak_plan[8'h98] = 4;
        run_table("nak_error");
        load_basic();
        nak_plan[8'h98] = 2;
        run_table("nak_retry");

        // Delay entry between two writes
        clear_table();
        rom[0] = 16'h4110;
        rom[1] = 16'hFE02;
        rom[2] = 16'h9803;
        run_table("delay");

        // Randomised tables, including full tables without an end marker
        for (int t = 0; t < 6; t++) begin
            clear_table();
            n = $urandom_range(1, NUM_REGS);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    rom[i] = {8'hFE, 8'($urandom_range(0, 1))};
                end else begin
                    r = {4'(i), 4'($urandom_range(0, 15))};
                    rom[i] = {r, 8'($urandom)};
                    n = n;
                    nak_plan[r] = int'($urandom_range(0, 5));
                    if (nak_plan[r] < 2) nak_plan[r] = 0;
                    else nak_plan[r] = nak_plan[r] - 1;
                end
            end
            run_table("random");
        end

        // Short interrupt glitch: no run
        intn_low(DEBOUNCE - 1);
        repeat (1500) @(negedge clk);
        check("glitch_runs", 32'(busy_rises), 32'(exp_runs));

        // Accepted interrupt after a completed run: one full rerun
        clear_table();
        rom[0] = 16'h4110;
        rom[1] = 16'hFE02;
        rom[2] = 16'h9803;
        model_run();
        nak_left = nak_plan;
        fork
            intn_low(1100);
            begin
                wait_busy(1'b1, 1300, "intn_run_start");
                wait_busy(1'b0, 30000, "intn_run_end");
            end
        join
        repeat (1500) @(negedge clk);
        check("intn_runs", 32'(busy_rises), 32'(exp_runs));

        // Two interrupt edges plus a start pulse while busy: exactly one rerun
        clear_table();
        rom[0] = 16'hFE03;
        rom[1] = 16'h4110;
        rom[2] = 16'hFE03;
        rom[3] = 16'h9803;
        model_run();
        model_run();
        nak_left = nak_plan;
        fork
            begin
                pulse_start();
                wait_busy(1'b1, 50, "multi_start");
                wait_busy(1'b0, 30000, "multi_end");
                wait_busy(1'b1, 50, "multi_rerun_start");
                wait_busy(1'b0, 30000, "multi_rerun_end");
            end
            begin
                repeat (100) @(negedge clk);
                intn_low(1100);
                repeat (1100) @(negedge clk);
                intn_low(1100);
                pulse_start();
            end
        join
        repeat (3000) @(negedge clk);
        check("multi_runs", 32'(busy_rises), 32'(exp_runs));

        // Reset while a request is outstanding
        load_basic();
        slave_hold = 1'b1;
        model_run();
        nak_left = nak_plan;
        pulse_start();
        n = 0;
        while (i2c_req !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (i2c_req !== 1'b1) fail("reset_req_wait: i2c_req never rose within 200 cycles");
        resetn = 1'b0;
        @(negedge clk);
        check("mid_rst_req", 32'(i2c_req), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_done", 32'(done), 32'(0));
        check("mid_rst_error", 32'(error), 32'(0));
        check("mid_rst_addr", 32'(cfg_addr), 32'(0));
        check("mid_rst_err_index", 32'(err_index), 32'(0));
        repeat (2) @(negedge clk);
        exp_reqs.delete();
        exp_stats.delete();
        slave_hold = 1'b0;
        resetn = 1'b1;
        repeat (300) @(negedge clk);
        check("post_rst_runs", 32'(busy_rises), 32'(exp_runs));
        check("post_rst_req", 32'(i2c_req), 32'(0));
        run_table("post_reset");

        check("reqs_left", 32'(exp_reqs.size()), 32'(0));
        check("stats_left", 32'(exp_stats.size()), 32'(0));
        check("total_runs", 32'(busy_rises), 32'(exp_runs));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
